// File: rtl/vga_plot_sink_pkg.sv
// Shared types and constants for the VGA plot sink: screen geometry,
// framebuffer address width, the queued plot command and the FSM states.
package vga_plot_sink_pkg;

    localparam int DEF_H_PIX      = 160;
    localparam int DEF_V_PIX      = 120;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int FB_AW          = 15;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } plot_cmd_t;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } sink_state_t;

    // Row-major pixel address y*h_pix + x. For h_pix=160 the constant
    // multiply reduces to (y<<7)+(y<<5)+x.
    function automatic logic [FB_AW-1:0] fb_addr(input logic [7:0] x,
                                                 input logic [6:0] y,
                                                 input int h_pix);
        return FB_AW'(int'(y) * h_pix + int'(x));
    endfunction

endpackage

// File: rtl/vga_plot_sink_if.sv
// VGA plot bus between a drawing engine (master) and the sink (slave).
// Handshake: vga_plot is a valid strobe with no ready/back-pressure; every
// cycle it is high carries exactly one {vga_x, vga_y, vga_colour} command.
// Commands the sink cannot queue are dropped and reported by its counters.
interface vga_plot_sink_if;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (output vga_x, output vga_y, output vga_colour, output vga_plot);
    modport slave  (input  vga_x, input  vga_y, input  vga_colour, input  vga_plot);
endinterface

// File: rtl/vga_plot_sink_fifo.sv
// Synchronous first-word-fall-through FIFO of plot commands. Full and empty
// are registered, so a push while full is dropped even if a pop happens in
// the same cycle.
module vga_plot_sink_fifo
    import vga_plot_sink_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_push,
    input  plot_cmd_t i_data,
    input  logic      i_pop,
    output plot_cmd_t o_data,
    output logic      o_full,
    output logic      o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    plot_cmd_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_full;
    logic            r_empty;
    logic            w_do_push;
    logic            w_do_pop;
    logic [CW-1:0]   w_count_next;

    assign w_do_push    = i_push && !r_full;
    assign w_do_pop     = i_pop && !r_empty;
    assign w_count_next = r_count + CW'(w_do_push) - CW'(w_do_pop);
    assign o_data       = r_mem[r_rd_ptr];
    assign o_full       = r_full;
    assign o_empty      = r_empty;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers, occupancy and the registered flags derived from next occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

endmodule

// File: rtl/vga_plot_sink.sv
// Consumer end of the VGA plot bus: queues in-range plot commands, drains
// them into a single-port H_PIX x V_PIX x 3 framebuffer and serves a
// registered read port. Reads win the RAM port over drain and clear.
module vga_plot_sink
    import vga_plot_sink_pkg::*;
#(
    parameter int H_PIX      = DEF_H_PIX,
    parameter int V_PIX      = DEF_V_PIX,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vga_plot_sink_if.slave        plot_bus,
    input  logic                  clear,
    output logic                  busy,
    input  logic                  rd_req,
    input  logic [7:0]            rd_x,
    input  logic [6:0]            rd_y,
    output logic                  rd_valid,
    output logic [2:0]            rd_colour,
    output logic [15:0]           plot_count,
    output logic [7:0]            oob_count,
    output logic                  overflow,
    output sink_state_t           o_dbg_state
);

    localparam int               FB_SIZE   = H_PIX * V_PIX;
    localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(FB_SIZE - 1);
    localparam logic [7:0]       X_LIM     = 8'(H_PIX);
    localparam logic [6:0]       Y_LIM     = 7'(V_PIX);

    sink_state_t      r_state;
    sink_state_t      w_state_next;
    logic [FB_AW-1:0] r_clr_addr;
    logic [FB_AW-1:0] w_clr_addr_next;
    logic             w_clr_we;
    logic             w_pop;

    logic [2:0]       r_fb [FB_SIZE];
    logic [2:0]       r_ram_q;
    logic             r_rd_valid;
    logic             r_rd_hit;
    logic [15:0]      r_plot_count;
    logic [7:0]       r_oob_count;
    logic             r_overflow;

    logic             w_plot_in_range;
    logic             w_push;
    logic             w_rd_in_range;
    logic             w_rd_access;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    plot_cmd_t        w_fifo_in;
    plot_cmd_t        w_fifo_q;
    logic             w_we;
    logic [FB_AW-1:0] w_wr_addr;
    logic [FB_AW-1:0] w_rd_addr;
    logic [2:0]       w_wdata;

    assign w_plot_in_range = (plot_bus.vga_x < X_LIM) && (plot_bus.vga_y < Y_LIM);
    assign w_push          = plot_bus.vga_plot && w_plot_in_range;
    assign w_fifo_in       = '{x: plot_bus.vga_x, y: plot_bus.vga_y, colour: plot_bus.vga_colour};

    // Out-of-range reads never touch the RAM, so they never stall drain/clear.
    assign w_rd_in_range   = (rd_x < X_LIM) && (rd_y < Y_LIM);
    assign w_rd_access     = rd_req && w_rd_in_range;

    vga_plot_sink_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_fifo_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_q),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // FSM state and clear-address register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_next;
            r_clr_addr <= w_clr_addr_next;
        end
    end

    // Next state: step the clear or drain the FIFO, yielding to reads.
    always_comb begin
        w_state_next    = r_state;
        w_clr_addr_next = r_clr_addr;
        w_clr_we        = 1'b0;
        w_pop           = 1'b0;
        case (r_state)
            S_CLEAR: begin
                if (clear) begin
                    w_clr_addr_next = '0;
                end else if (!w_rd_access) begin
                    w_clr_we = 1'b1;
                    if (r_clr_addr == LAST_ADDR) begin
                        w_state_next    = S_RUN;
                        w_clr_addr_next = '0;
                    end else begin
                        w_clr_addr_next = r_clr_addr + FB_AW'(1);
                    end
                end
            end
            S_RUN: begin
                w_pop = !w_fifo_empty && !w_rd_access;
                if (clear) begin
                    w_state_next    = S_CLEAR;
                    w_clr_addr_next = '0;
                end
            end
            default: begin
                w_state_next = S_CLEAR;
            end
        endcase
    end

    assign w_we      = w_clr_we || w_pop;
    assign w_wr_addr = (r_state == S_CLEAR) ? r_clr_addr : fb_addr(w_fifo_q.x, w_fifo_q.y, H_PIX);
    assign w_wdata   = (r_state == S_CLEAR) ? 3'd0 : w_fifo_q.colour;
    assign w_rd_addr = fb_addr(rd_x, rd_y, H_PIX);

    // Single-port framebuffer: one read or one write per cycle, read first.
    always_ff @(posedge clk) begin
        if (w_rd_access) begin
            r_ram_q <= r_fb[w_rd_addr];
        end else if (w_we) begin
            r_fb[w_wr_addr] <= w_wdata;
        end
    end

    // Read-port qualifiers, saturating counters and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid   <= 1'b0;
            r_rd_hit     <= 1'b0;
            r_plot_count <= '0;
            r_oob_count  <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_rd_valid <= rd_req;
            r_rd_hit   <= w_rd_access;
            if (w_pop && (r_plot_count != 16'hFFFF)) begin
                r_plot_count <= r_plot_count + 16'd1;
            end
            if (plot_bus.vga_plot && !w_plot_in_range && (r_oob_count != 8'hFF)) begin
                r_oob_count <= r_oob_count + 8'd1;
            end
            if (w_push && w_fifo_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign busy        = (r_state == S_CLEAR);
    assign rd_valid    = r_rd_valid;
    assign rd_colour   = r_rd_hit ? r_ram_q : 3'd0;
    assign plot_count  = r_plot_count;
    assign oob_count   = r_oob_count;
    assign overflow    = r_overflow;
    assign o_dbg_state = r_state;

endmodule
